// File: rtl/pic10f200_pkg.sv
// Shared opcode field codes and the decoded ALU operation type for the
// PIC10F200 byte-oriented ALU.
package pic10f200_pkg;

  // opcode[11:6] codes for the byte-oriented file ops
  localparam logic [5:0] OP6_ADDWF  = 6'b000111;
  localparam logic [5:0] OP6_ANDWF  = 6'b000101;
  localparam logic [5:0] OP6_IORWF  = 6'b000100;
  localparam logic [5:0] OP6_XORWF  = 6'b000110;
  localparam logic [5:0] OP6_SUBWF  = 6'b000010;
  localparam logic [5:0] OP6_COMF   = 6'b001001;
  localparam logic [5:0] OP6_DECF   = 6'b000011;
  localparam logic [5:0] OP6_INCF   = 6'b001010;
  localparam logic [5:0] OP6_DECFSZ = 6'b001011;
  localparam logic [5:0] OP6_INCFSZ = 6'b001111;
  localparam logic [5:0] OP6_MOVF   = 6'b001000;
  localparam logic [5:0] OP6_RLF    = 6'b001101;
  localparam logic [5:0] OP6_RRF    = 6'b001100;
  localparam logic [5:0] OP6_SWAPF  = 6'b001110;

  // opcode[11:5] codes for the ops without a d bit
  localparam logic [6:0] OP7_MOVWF = 7'b0000001;
  localparam logic [6:0] OP7_CLRF  = 7'b0000011;
  localparam logic [6:0] OP7_CLRW  = 7'b0000010;

  localparam logic [11:0] CLRW_WORD = 12'h040;

  typedef enum logic [4:0] {
    ALU_NONE,
    ALU_ADDWF,
    ALU_ANDWF,
    ALU_IORWF,
    ALU_XORWF,
    ALU_SUBWF,
    ALU_COMF,
    ALU_DECF,
    ALU_INCF,
    ALU_DECFSZ,
    ALU_INCFSZ,
    ALU_MOVF,
    ALU_RLF,
    ALU_RRF,
    ALU_SWAPF,
    ALU_MOVWF,
    ALU_CLRF,
    ALU_CLRW
  } alu_op_e;

endpackage

// File: rtl/pic10f200_alu_decode.sv
// Instruction decoder: maps a 12-bit instruction word to an ALU operation,
// destination select and a supported-op indication.
module pic10f200_alu_decode
  import pic10f200_pkg::*;
(
  input  logic [11:0] opcode,
  output alu_op_e     op,
  output logic        dest,
  output logic        valid
);

  always_comb begin
    op    = ALU_NONE;
    dest  = 1'b0;
    valid = 1'b1;
    case (opcode[11:6])
      OP6_ADDWF:  op = ALU_ADDWF;
      OP6_ANDWF:  op = ALU_ANDWF;
      OP6_IORWF:  op = ALU_IORWF;
      OP6_XORWF:  op = ALU_XORWF;
      OP6_SUBWF:  op = ALU_SUBWF;
      OP6_COMF:   op = ALU_COMF;
      OP6_DECF:   op = ALU_DECF;
      OP6_INCF:   op = ALU_INCF;
      OP6_DECFSZ: op = ALU_DECFSZ;
      OP6_INCFSZ: op = ALU_INCFSZ;
      OP6_MOVF:   op = ALU_MOVF;
      OP6_RLF:    op = ALU_RLF;
      OP6_RRF:    op = ALU_RRF;
      OP6_SWAPF:  op = ALU_SWAPF;
      default: begin
        valid = 1'b0;
        // CLRW only decodes from its exact word; other low-bit values are reserved
        if (opcode[11:5] == OP7_MOVWF) begin
          op    = ALU_MOVWF;
          valid = 1'b1;
        end else if (opcode[11:5] == OP7_CLRF) begin
          op    = ALU_CLRF;
          valid = 1'b1;
        end else if (opcode == CLRW_WORD) begin
          op    = ALU_CLRW;
          valid = 1'b1;
        end
      end
    endcase

    if (valid) begin
      case (op)
        ALU_MOVWF, ALU_CLRF: dest = 1'b1;
        ALU_CLRW:            dest = 1'b0;
        default:             dest = opcode[5];
      endcase
    end
  end

endmodule

// File: rtl/pic10f200_alu.sv
// Registered byte-oriented ALU: decodes the instruction, computes result and
// STATUS flag updates, and captures everything one cycle later when enabled.
module pic10f200_alu
  import pic10f200_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  f,
  input  logic [7:0]  w,
  input  logic [11:0] opcode,
  input  logic        c_in,
  output logic [7:0]  R,
  output logic        z_flag,
  output logic        c_flag,
  output logic        dc_flag,
  output logic        z_we,
  output logic        c_we,
  output logic        dc_we,
  output logic        dest,
  output logic        skip,
  output logic        valid
);

  alu_op_e    op;
  logic       dec_dest, dec_valid;
  logic [8:0] add_full;
  logic [4:0] add_half;

  logic [7:0] r_d, r_q;
  logic       z_d, c_d, dc_d, z_we_d, c_we_d, dc_we_d, dest_d, skip_d, valid_d;
  logic       z_q, c_q, dc_q, z_we_q, c_we_q, dc_we_q, dest_q, skip_q, valid_q;

  pic10f200_alu_decode u_decode (
    .opcode (opcode),
    .op     (op),
    .dest   (dec_dest),
    .valid  (dec_valid)
  );

  assign add_full = {1'b0, f} + {1'b0, w};
  assign add_half = {1'b0, f[3:0]} + {1'b0, w[3:0]};

  always_comb begin
    r_d     = 8'h00;
    c_d     = 1'b0;
    dc_d    = 1'b0;
    z_we_d  = 1'b0;
    c_we_d  = 1'b0;
    dc_we_d = 1'b0;
    skip_d  = 1'b0;
    dest_d  = dec_dest;
    valid_d = dec_valid;
    case (op)
      ALU_ADDWF: begin
        r_d = add_full[7:0]; c_d = add_full[8]; dc_d = add_half[4];
        z_we_d = 1'b1; c_we_d = 1'b1; dc_we_d = 1'b1;
      end
      // C and DC are "no borrow" for subtraction
      ALU_SUBWF: begin
        r_d = f - w; c_d = (f >= w); dc_d = (f[3:0] >= w[3:0]);
        z_we_d = 1'b1; c_we_d = 1'b1; dc_we_d = 1'b1;
      end
      ALU_ANDWF:  begin r_d = f & w;  z_we_d = 1'b1; end
      ALU_IORWF:  begin r_d = f | w;  z_we_d = 1'b1; end
      ALU_XORWF:  begin r_d = f ^ w;  z_we_d = 1'b1; end
      ALU_COMF:   begin r_d = ~f;     z_we_d = 1'b1; end
      ALU_DECF:   begin r_d = f - 8'd1; z_we_d = 1'b1; end
      ALU_INCF:   begin r_d = f + 8'd1; z_we_d = 1'b1; end
      ALU_DECFSZ: begin r_d = f - 8'd1; skip_d = (f == 8'h01); end
      ALU_INCFSZ: begin r_d = f + 8'd1; skip_d = (f == 8'hFF); end
      ALU_MOVF:   begin r_d = f;      z_we_d = 1'b1; end
      ALU_RLF:    begin r_d = {f[6:0], c_in}; c_d = f[7]; c_we_d = 1'b1; end
      ALU_RRF:    begin r_d = {c_in, f[7:1]}; c_d = f[0]; c_we_d = 1'b1; end
      ALU_SWAPF:  r_d = {f[3:0], f[7:4]};
      ALU_MOVWF:  r_d = w;
      ALU_CLRF, ALU_CLRW: begin r_d = 8'h00; z_we_d = 1'b1; end
      default: begin
        dest_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
    z_d = z_we_d & (r_d == 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= 8'h00;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      dc_q    <= 1'b0;
      z_we_q  <= 1'b0;
      c_we_q  <= 1'b0;
      dc_we_q <= 1'b0;
      dest_q  <= 1'b0;
      skip_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (en) begin
      r_q     <= r_d;
      z_q     <= z_d;
      c_q     <= c_d;
      dc_q    <= dc_d;
      z_we_q  <= z_we_d;
      c_we_q  <= c_we_d;
      dc_we_q <= dc_we_d;
      dest_q  <= dest_d;
      skip_q  <= skip_d;
      valid_q <= valid_d;
    end
  end

  assign R       = r_q;
  assign z_flag  = z_q;
  assign c_flag  = c_q;
  assign dc_flag = dc_q;
  assign z_we    = z_we_q;
  assign c_we    = c_we_q;
  assign dc_we   = dc_we_q;
  assign dest    = dest_q;
  assign skip    = skip_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_pic10f200_alu.sv
// Self-checking bench for pic10f200_alu: directed cases followed by random
// instruction streams compared against an arithmetic reference model.
module tb_pic10f200_alu;

  typedef struct packed {
    logic [7:0] r;
    logic       z, c, dc, z_we, c_we, dc_we, dest, skip, valid;
  } alu_out_t;

  logic        clk = 1'b0;
  logic        rst, en, c_in;
  logic [7:0]  f, w;
  logic [11:0] opcode;
  logic [7:0]  R;
  logic        z_flag, c_flag, dc_flag, z_we, c_we, dc_we, dest, skip, valid;

  int       checks = 0;
  int       errors = 0;
  alu_out_t expected = '0;

  pic10f200_alu dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .f       (f),
    .w       (w),
    .opcode  (opcode),
    .c_in    (c_in),
    .R       (R),
    .z_flag  (z_flag),
    .c_flag  (c_flag),
    .dc_flag (dc_flag),
    .z_we    (z_we),
    .c_we    (c_we),
    .dc_we   (dc_we),
    .dest    (dest),
    .skip    (skip),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  // Reference model: instruction semantics in plain integer arithmetic
  function automatic alu_out_t model(input logic [11:0] op, input int fv, input int wv,
                                     input int cin);
    alu_out_t o = '0;
    int res = 0;
    o.valid = 1'b1;
    o.dest  = op[5];
    case (op[11:6])
      6'b000111: begin res = (fv + wv) % 256; o.c = (fv + wv) > 255;
                 o.dc = ((fv % 16) + (wv % 16)) > 15; o.z_we = 1; o.c_we = 1; o.dc_we = 1; end
      6'b000101: begin res = fv & wv; o.z_we = 1; end
      6'b000100: begin res = fv | wv; o.z_we = 1; end
      6'b000110: begin res = fv ^ wv; o.z_we = 1; end
      6'b000010: begin res = (fv - wv + 256) % 256; o.c = fv >= wv;
                 o.dc = (fv % 16) >= (wv % 16); o.z_we = 1; o.c_we = 1; o.dc_we = 1; end
      6'b001001: begin res = 255 - fv; o.z_we = 1; end
      6'b000011: begin res = (fv + 255) % 256; o.z_we = 1; end
      6'b001010: begin res = (fv + 1) % 256; o.z_we = 1; end
      6'b001011: begin res = (fv + 255) % 256; o.skip = (res == 0); end
      6'b001111: begin res = (fv + 1) % 256; o.skip = (res == 0); end
      6'b001000: begin res = fv; o.z_we = 1; end
      6'b001101: begin res = (fv * 2 + cin) % 256; o.c = fv >= 128; o.c_we = 1; end
      6'b001100: begin res = fv / 2 + cin * 128; o.c = (fv % 2) == 1; o.c_we = 1; end
      6'b001110: begin res = (fv % 16) * 16 + fv / 16; end
      default: begin
        if (op[11:5] == 7'b0000001) begin res = wv; o.dest = 1; end
        else if (op[11:5] == 7'b0000011) begin res = 0; o.dest = 1; o.z_we = 1; end
        else if (op == 12'h040) begin res = 0; o.dest = 0; o.z_we = 1; end
        else o = '0;
      end
    endcase
    o.r = res[7:0];
    o.z = o.z_we && (res == 0);
    return o;
  endfunction

  task automatic checkOutput(input string tag, input alu_out_t actual, input alu_out_t exp_v);
    checks++;
    if (actual !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %h (R=%h z/c/dc=%b%b%b we=%b%b%b d=%b s=%b v=%b) required %h (R=%h z/c/dc=%b%b%b we=%b%b%b d=%b s=%b v=%b)",
               tag, actual, actual.r, actual.z, actual.c, actual.dc, actual.z_we, actual.c_we,
               actual.dc_we, actual.dest, actual.skip, actual.valid,
               exp_v, exp_v.r, exp_v.z, exp_v.c, exp_v.dc, exp_v.z_we, exp_v.c_we,
               exp_v.dc_we, exp_v.dest, exp_v.skip, exp_v.valid);
    end
  endtask

  // Drive one cycle of inputs, track the expected registered state, then check
  task automatic applyStimulus(input string tag, input logic r_i, input logic en_i,
                               input logic [11:0] op_i, input logic [7:0] f_i,
                               input logic [7:0] w_i, input logic cin_i);
    alu_out_t actual;
    @(negedge clk);
    rst = r_i; en = en_i; opcode = op_i; f = f_i; w = w_i; c_in = cin_i;
    if (r_i) expected = '0;
    else if (en_i) expected = model(op_i, int'(f_i), int'(w_i), int'(cin_i));
    @(posedge clk);
    #1;
    actual = {R, z_flag, c_flag, dc_flag, z_we, c_we, dc_we, dest, skip, valid};
    checkOutput(tag, actual, expected);
  endtask

  logic [11:0] bases [17] = '{12'h1C0, 12'h140, 12'h100, 12'h180, 12'h080, 12'h240,
                              12'h0C0, 12'h280, 12'h2C0, 12'h3C0, 12'h200, 12'h340,
                              12'h300, 12'h380, 12'h020, 12'h060, 12'h040};

  initial begin
    logic [11:0] op_r;
    int idx;
    rst = 1'b1; en = 1'b0; opcode = '0; f = '0; w = '0; c_in = 1'b0;

    applyStimulus("reset0", 1, 1, 12'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    applyStimulus("reset1", 1, 1, 12'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    applyStimulus("release_hold", 0, 0, 12'h1FF, 8'h01, 8'h02, 0);

    applyStimulus("addwf", 0, 1, 12'h1FF, 8'h01, 8'h02, 0);
    applyStimulus("andwf", 0, 1, 12'h17F, 8'h01, 8'h02, 0);
    applyStimulus("iorwf", 0, 1, 12'h13F, 8'h01, 8'h02, 0);
    applyStimulus("xorwf", 0, 1, 12'h1BF, 8'h01, 8'h02, 0);
    applyStimulus("subwf", 0, 1, 12'h0BF, 8'h01, 8'h02, 0);
    applyStimulus("comf",  0, 1, 12'h27F, 8'h01, 8'h02, 0);
    applyStimulus("swapf", 0, 1, 12'h3BF, 8'h01, 8'h02, 0);
    applyStimulus("movwf", 0, 1, 12'h03F, 8'h01, 8'h02, 0);
    applyStimulus("clrw",  0, 1, 12'h040, 8'h01, 8'h02, 0);
    applyStimulus("clrf",  0, 1, 12'h07F, 8'h01, 8'h02, 0);
    applyStimulus("decf",  0, 1, 12'h0FF, 8'h01, 8'h02, 0);
    applyStimulus("decfsz", 0, 1, 12'h2FF, 8'h01, 8'h02, 0);
    applyStimulus("incf",  0, 1, 12'h2BF, 8'h01, 8'h02, 0);
    applyStimulus("incfsz", 0, 1, 12'h3FF, 8'h01, 8'h02, 0);
    applyStimulus("movf",  0, 1, 12'h23F, 8'h01, 8'h02, 0);
    applyStimulus("rlf",   0, 1, 12'h37F, 8'h01, 8'h02, 1);
    applyStimulus("rrf",   0, 1, 12'h33F, 8'h01, 8'h02, 0);

    applyStimulus("incf_wrap", 0, 1, 12'h2BF, 8'hFF, 8'h00, 0);
    applyStimulus("incfsz_wrap", 0, 1, 12'h3FF, 8'hFF, 8'h00, 0);
    applyStimulus("decf_wrap", 0, 1, 12'h0FF, 8'h00, 8'h00, 0);
    applyStimulus("addwf_dc", 0, 1, 12'h1FF, 8'h0F, 8'h01, 0);
    applyStimulus("addwf_carry", 0, 1, 12'h1FF, 8'hFF, 8'h01, 0);
    applyStimulus("subwf_equal", 0, 1, 12'h0BF, 8'h05, 8'h05, 0);
    applyStimulus("rlf_c7", 0, 1, 12'h37F, 8'h80, 8'h00, 0);
    applyStimulus("rrf_cin", 0, 1, 12'h33F, 8'h02, 8'h00, 1);

    applyStimulus("nop", 0, 1, 12'h000, 8'h01, 8'h02, 0);
    applyStimulus("clrw_bad", 0, 1, 12'h041, 8'h01, 8'h02, 0);
    applyStimulus("bcf", 0, 1, 12'h400, 8'h01, 8'h02, 0);

    applyStimulus("load", 0, 1, 12'h1FF, 8'h0F, 8'h01, 0);
    applyStimulus("hold0", 0, 0, 12'h07F, 8'h33, 8'h44, 1);
    applyStimulus("hold1", 0, 0, 12'h2FF, 8'h01, 8'h44, 0);
    applyStimulus("rst_en", 1, 1, 12'h1FF, 8'hFF, 8'h01, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        op_r = 12'($urandom);
      end else begin
        idx  = $urandom_range(0, 16);
        op_r = bases[idx];
        if (idx < 14) op_r = op_r | 12'($urandom_range(0, 63));
        else if (idx < 16) op_r = op_r | 12'($urandom_range(0, 31));
      end
      applyStimulus("random", ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
                    op_r, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic10f200_alu.md
Name: pic10f200_alu

Overview:
- Registered byte-oriented ALU for a PIC10F200-style core.
- Decodes the 12-bit instruction word and combines file operand f, working register w and carry-in.
- Produces an 8-bit result plus status-flag values, flag write strobes, destination select and skip indication.
- Sits between the register-file read port and the writeback/STATUS logic.

Parameters:
- none (widths fixed by the PIC10F200 ISA)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  capture enable; outputs load only when en=1
- f  in  8  file-register operand
- w  in  8  working-register operand
- opcode  in  12  instruction word
- c_in  in  1  current STATUS.C, used by RLF/RRF
- R  out  8  result
- z_flag, c_flag, dc_flag  out  1 each  new flag values
- z_we, c_we, dc_we  out  1 each  flag update strobes
- dest  out  1  opcode[5] (d bit): 0 writes W, 1 writes f; forced 1 for MOVWF/CLRF, 0 for CLRW
- skip  out  1  DECFSZ/INCFSZ result is zero
- valid  out  1  opcode is a supported byte-oriented op

Behaviour:
- All outputs are registered.
  - On a rising clk edge with rst=1, every output clears to 0.
  - Otherwise, with en=1, all outputs load from the combinational decode of the current inputs. Latency is one cycle.
  - With en=0, outputs hold.
  - rst has priority over en.
- Decode on opcode[11:6] (opcode[4:0] is the file address and is ignored):
  - 000111 ADDWF: R=f+w; C=carry out of bit 7; DC=carry out of bit 3; Z
  - 000101 ANDWF: R=f&w; Z
  - 000100 IORWF: R=f|w; Z
  - 000110 XORWF: R=f^w; Z
  - 000010 SUBWF: R=f-w (mod 256); C=1 when f>=w (no borrow); DC=1 when f[3:0]>=w[3:0]; Z
  - 001001 COMF: R=~f; Z
  - 000011 DECF: R=f-1; Z
  - 001010 INCF: R=f+1; Z
  - 001011 DECFSZ: R=f-1; skip=(R==0); no flags
  - 001111 INCFSZ: R=f+1; skip=(R==0); no flags
  - 001000 MOVF: R=f; Z
  - 001101 RLF: R={f[6:0],c_in}; C=f[7]
  - 001100 RRF: R={c_in,f[7:1]}; C=f[0]
  - 001110 SWAPF: R={f[3:0],f[7:4]}; no flags
- Decode on opcode[11:5]:
  - 0000001 MOVWF: R=w; no flags
  - 0000011 CLRF: R=0; Z=1
  - 0000010 CLRW: R=0; Z=1. Valid only when opcode==12'h040; any other low-5-bit value is invalid.
- Z means z_flag=(R==0). Each strobe is 1 only for the ops listed as updating that flag. A flag value output is 0 whenever its strobe is 0.
- Arithmetic wraps modulo 256, e.g. INCF 0xFF gives 0x00 with Z=1, and DECF 0x00 gives 0xFF.
- Anything else (NOP/OPTION/SLEEP/CLRWDT/TRIS, bit-oriented, literal, control) is invalid: valid=0, R=0, all strobes, skip and dest = 0.
- valid=1 for every supported op.

Decomposition:
- Package pic10f200_pkg holds the opcode-field localparams (6-bit and 7-bit op codes, CLRW full word) and an enumerated ALU-op type.
- Optional sub-module pic10f200_alu_decode: opcode in, op enum / dest / valid out. The datapath and output registers stay in the top.

Test Plan:
- Reset: drive rst=1 for 2 cycles with random inputs -> all outputs 0. Then release with en=0 -> outputs remain 0.
- f=0x01, w=0x02, one op per cycle with en=1, checked one cycle later:
  - ADDWF (0x1FF) -> R=0x03, C=0, DC=0, Z=0
  - ANDWF (0x17F) -> R=0x00, Z=1
  - IORWF (0x13F) -> R=0x03
  - XORWF (0x1BF) -> R=0x03
  - SUBWF (0x0BF) -> R=0xFF, C=0, DC=0
  - COMF (0x27F) -> R=0xFE
  - SWAPF (0x3BF) -> R=0x10
  - MOVWF (0x03F) -> R=0x02, dest=1, no strobes
  - CLRW (0x040) -> R=0x00, Z=1, dest=0
  - CLRF (0x07F) -> R=0x00, Z=1, dest=1
- Same f/w, increment/decrement/skip ops:
  - DECF (0x0FF) -> R=0x00, Z=1
  - DECFSZ (0x2FF) -> R=0x00, skip=1, z_we=0
  - INCF (0x2BF) -> R=0x02
  - INCFSZ (0x3FF) -> R=0x02, skip=0
  - MOVF (0x23F) -> R=0x01, Z=0
- Rotates with f=0x01:
  - RLF (0x37F), c_in=1 -> R=0x03, C=0
  - RRF (0x33F), c_in=0 -> R=0x00, C=1
- Boundaries:
  - INCF f=0xFF -> R=0x00, Z=1
  - ADDWF f=0x0F, w=0x01 -> R=0x10, DC=1, C=0
  - ADDWF f=0xFF, w=0x01 -> R=0x00, C=1, DC=1, Z=1
  - SUBWF f=0x05, w=0x05 -> R=0x00, C=1, DC=1, Z=1
- Invalid and hold:
  - opcode 0x000 (NOP) -> valid=0, R=0
  - opcode 0x041 -> valid=0
  - opcode 0x400 (BCF) -> valid=0
  - en=0 mid-sequence -> previous outputs held
  - rst asserted with en=1 -> outputs clear
